// File: rtl/ball_animate_pkg.sv
// Shared Breakout definitions: screen geometry, paddle rows, object colours
// and the ball state encoding used by the ball and brick stages.
package ball_animate_pkg;

    localparam int MAX_X   = 640;
    localparam int MAX_Y   = 480;
    localparam int BAR_Y_T = 429;
    localparam int BAR_Y_B = 436;

    localparam logic [23:0] BALL_COLOR = 24'hFF0000;
    localparam logic [23:0] BAR_COLOR  = 24'h00FF00;
    localparam logic [23:0] WALL_COLOR = 24'h0000FF;
    localparam logic [23:0] BG_COLOR   = 24'h000000;

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_MISS  = 2'd2,
        ST_OVER  = 2'd3
    } ball_state_t;

endpackage

// File: rtl/ball_animate_rect_on.sv
// Pixel-in-rectangle test for a W x H object whose top-left corner is
// (rect_x, rect_y). Shared by the ball and brick stages.
module rect_on #(
    parameter int W = 8,
    parameter int H = 8
) (
    input  logic [11:0] pix_x,
    input  logic [11:0] pix_y,
    input  logic [11:0] rect_x,
    input  logic [11:0] rect_y,
    output logic        on
);

    // One extra bit so an object touching the screen edge cannot wrap.
    logic [12:0] x_end;
    logic [12:0] y_end;

    assign x_end = {1'b0, rect_x} + 13'(W);
    assign y_end = {1'b0, rect_y} + 13'(H);

    assign on = (pix_x >= rect_x) && ({1'b0, pix_x} < x_end) &&
                (pix_y >= rect_y) && ({1'b0, pix_y} < y_end);

endmodule

// File: rtl/ball_animate.sv
// Breakout ball motion engine: serve, wall/paddle/brick bounces, miss
// detection, lives bookkeeping and the ball pixel for the RGB mux.
module ball_animate
    import ball_animate_pkg::*;
#(
    parameter int          BALL_SIZE   = 8,
    parameter int          BALL_V      = 2,
    parameter int          SERVE_X     = 316,
    parameter int          SERVE_Y     = 300,
    parameter int          SERVE_DELAY = 75,
    parameter int          LIVES_INIT  = 3,
    parameter logic [23:0] BALL_RGB    = BALL_COLOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick75hz,
    input  logic        launch,
    input  logic        brick_bounce,
    input  logic [11:0] pix_x,
    input  logic [11:0] pix_y,
    input  logic [11:0] bar_x_l,
    input  logic [11:0] bar_x_r,
    output logic [11:0] ball_x,
    output logic [11:0] ball_y,
    output logic        ball_on,
    output logic [23:0] ball_rgb,
    output logic        paddle_hit,
    output logic        miss,
    output logic [1:0]  lives,
    output logic        game_over
);

    localparam logic [11:0] SZ        = 12'(BALL_SIZE);
    localparam logic [11:0] V         = 12'(BALL_V);
    localparam logic [11:0] X0        = 12'(SERVE_X);
    localparam logic [11:0] Y0        = 12'(SERVE_Y);
    localparam logic [11:0] RIGHT_LIM = 12'(MAX_X - BALL_V);
    localparam logic [11:0] FLOOR     = 12'(MAX_Y);
    localparam logic [11:0] PAD_LO    = 12'(BAR_Y_T);
    localparam logic [11:0] PAD_HI    = 12'(BAR_Y_T + BALL_V);
    localparam int          CW        = $clog2(SERVE_DELAY + 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(SERVE_DELAY - 1);
    localparam logic [1:0]  LIVES0    = 2'(LIVES_INIT);

    ball_state_t   state, state_d;
    logic [11:0]   x_d, y_d;
    logic          dir_x, dir_y, dx_d, dy_d;   // 1 = right / down
    logic [1:0]    lives_d;
    logic [CW-1:0] delay_cnt, cnt_d;
    logic          brick_latch, brick_d;
    logic          hit_d, miss_d;

    logic [11:0] ball_bot;
    logic        hit_left, hit_right, hit_top, hit_paddle, at_floor, brick_pend;
    logic        in_rect;

    assign ball_bot   = ball_y + SZ;
    assign hit_left   = !dir_x && (ball_x <= V);
    assign hit_right  = dir_x && (ball_x + SZ >= RIGHT_LIM);
    assign hit_top    = !dir_y && (ball_y <= V);
    assign hit_paddle = dir_y && (ball_bot >= PAD_LO) && (ball_bot <= PAD_HI) &&
                        (ball_x + SZ - 12'd1 >= bar_x_l) && (ball_x <= bar_x_r);
    assign at_floor   = ball_bot >= FLOOR;
    // A brick hit arriving on the tick cycle itself is consumed by that tick.
    assign brick_pend = brick_latch || brick_bounce;

    always_ff @(posedge clk) begin
        // NOTE: every register uses <= so all of them sample pre-edge values.
        if (reset) begin
            state       <= ST_SERVE;
            ball_x      <= X0;
            ball_y      <= Y0;
            dir_x       <= 1'b1;
            dir_y       <= 1'b0;
            lives       <= LIVES0;
            delay_cnt   <= '0;
            brick_latch <= 1'b0;
            paddle_hit  <= 1'b0;
            miss        <= 1'b0;
        end else begin
            state       <= state_d;
            ball_x      <= x_d;
            ball_y      <= y_d;
            dir_x       <= dx_d;
            dir_y       <= dy_d;
            lives       <= lives_d;
            delay_cnt   <= cnt_d;
            brick_latch <= brick_d;
            paddle_hit  <= hit_d;
            miss        <= miss_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path infers a latch.
        state_d = state;
        x_d     = ball_x;
        y_d     = ball_y;
        dx_d    = dir_x;
        dy_d    = dir_y;
        lives_d = lives;
        cnt_d   = delay_cnt;
        brick_d = 1'b0;
        hit_d   = 1'b0;
        miss_d  = 1'b0;

        unique case (state)
            ST_SERVE: begin
                if (tick75hz && launch) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                brick_d = brick_pend;
                if (tick75hz) begin
                    brick_d = 1'b0;
                    if (at_floor) begin
                        miss_d  = 1'b1;
                        lives_d = lives - 2'd1;
                        cnt_d   = '0;
                        state_d = ST_MISS;
                    end else begin
                        if (hit_left)       dx_d = 1'b1;
                        else if (hit_right) dx_d = 1'b0;

                        // Wall and paddle bounces absorb a pending brick flip.
                        if (hit_top) begin
                            dy_d = 1'b1;
                        end else if (hit_paddle) begin
                            dy_d  = 1'b0;
                            hit_d = 1'b1;
                        end else if (brick_pend) begin
                            dy_d = !dir_y;
                        end

                        x_d = dx_d ? ball_x + V : ball_x - V;
                        y_d = dy_d ? ball_y + V : ball_y - V;
                    end
                end
            end
            ST_MISS: begin
                if (tick75hz) begin
                    if (delay_cnt == DELAY_LAST) begin
                        if (lives == 2'd0) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d = ST_SERVE;
                            x_d     = X0;
                            y_d     = Y0;
                            dx_d    = 1'b1;
                            dy_d    = 1'b0;
                        end
                    end else begin
                        cnt_d = delay_cnt + CW'(1);
                    end
                end
            end
            ST_OVER: begin
            end
            default: state_d = ST_SERVE;
        endcase
    end

    rect_on #(
        .W(BALL_SIZE),
        .H(BALL_SIZE)
    ) u_ball_rect (
        .pix_x (pix_x),
        .pix_y (pix_y),
        .rect_x(ball_x),
        .rect_y(ball_y),
        .on    (in_rect)
    );

    assign game_over = (state == ST_OVER);
    assign ball_on   = in_rect && !game_over;
    assign ball_rgb  = BALL_RGB;

endmodule

// File: tb/tb_ball_animate.sv
// Bench for ball_animate: a velocity-based motion model checked every cycle,
// plus directed scenarios with hand-derived positions.
module tb_ball_animate;

    logic        clk = 1'b0;
    logic        reset, tick75hz, launch, brick_bounce;
    logic [11:0] pix_x, pix_y, bar_x_l, bar_x_r;
    logic [11:0] ball_x, ball_y;
    logic        ball_on, paddle_hit, miss, game_over;
    logic [23:0] ball_rgb;
    logic [1:0]  lives;

    ball_animate dut (
        .clk         (clk),
        .reset       (reset),
        .tick75hz    (tick75hz),
        .launch      (launch),
        .brick_bounce(brick_bounce),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .bar_x_l     (bar_x_l),
        .bar_x_r     (bar_x_r),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .ball_on     (ball_on),
        .ball_rgb    (ball_rgb),
        .paddle_hit  (paddle_hit),
        .miss        (miss),
        .lives       (lives),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_SERVE, M_PLAY, M_MISS, M_OVER} mphase_t;
    mphase_t m_phase = M_SERVE;
    int  m_x = 0, m_y = 0, m_vx = 0, m_vy = 0, m_lives = 0, m_wait = 0;
    bit  m_brick = 0, m_hit = 0, m_miss = 0, m_turned = 0, model_ok = 0;
    int  hit_seen = 0, miss_seen = 0;

    function automatic void m_to_serve_point();
        m_x  = 316;
        m_y  = 300;
        m_vx = 2;
        m_vy = -2;
    endfunction

    always @(posedge clk) begin
        m_hit  = 0;
        m_miss = 0;
        if (reset) begin
            m_to_serve_point();
            m_lives  = 3;
            m_phase  = M_SERVE;
            m_wait   = 0;
            m_brick  = 0;
            model_ok = 1;
        end else begin
            case (m_phase)
                M_SERVE: if (tick75hz && launch) m_phase = M_PLAY;
                M_PLAY: begin
                    if (brick_bounce) m_brick = 1;
                    if (tick75hz) begin
                        if (m_y + 8 >= 480) begin
                            m_miss  = 1;
                            m_lives = m_lives - 1;
                            m_wait  = 0;
                            m_phase = M_MISS;
                        end else begin
                            if (m_vx < 0 && m_x <= 2) m_vx = 2;
                            else if (m_vx > 0 && m_x + 8 >= 638) m_vx = -2;
                            m_turned = 0;
                            if (m_vy < 0 && m_y <= 2) begin
                                m_vy = 2;
                                m_turned = 1;
                            end else if (m_vy > 0 && m_y + 8 >= 429 && m_y + 8 <= 431 &&
                                         m_x + 7 >= int'(bar_x_l) && m_x <= int'(bar_x_r)) begin
                                m_vy = -2;
                                m_hit = 1;
                                m_turned = 1;
                            end
                            if (m_brick && !m_turned) m_vy = -m_vy;
                            m_x = m_x + m_vx;
                            m_y = m_y + m_vy;
                        end
                        m_brick = 0;
                    end
                end
                M_MISS: begin
                    if (tick75hz) begin
                        m_wait = m_wait + 1;
                        if (m_wait == 75) begin
                            if (m_lives == 0) begin
                                m_phase = M_OVER;
                            end else begin
                                m_to_serve_point();
                                m_phase = M_SERVE;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-cycle comparison, well clear of the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (model_ok) begin
                check("ball_x", ball_x, m_x);
                check("ball_y", ball_y, m_y);
                check("lives", lives, m_lives);
                check("paddle_hit", paddle_hit, m_hit);
                check("miss", miss, m_miss);
                check("game_over", game_over, m_phase == M_OVER);
                check("ball_rgb", ball_rgb, 24'hFF0000);
                check("ball_on", ball_on,
                      m_phase != M_OVER &&
                      int'(pix_x) >= m_x && int'(pix_x) < m_x + 8 &&
                      int'(pix_y) >= m_y && int'(pix_y) < m_y + 8);
                if (paddle_hit) hit_seen++;
                if (miss) miss_seen++;
            end
        end
    end

    // Scan pixels around the modelled ball so both edges of ball_on are hit.
    initial begin
        forever begin
            @(negedge clk);
            pix_x = 12'(m_x - 2 + int'($urandom_range(0, 11)));
            pix_y = 12'(m_y - 2 + int'($urandom_range(0, 11)));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic tick_once(input bit with_brick);
        @(negedge clk);
        tick75hz     = 1'b1;
        brick_bounce = with_brick;
        @(negedge clk);
        tick75hz     = 1'b0;
        brick_bounce = 1'b0;
    endtask

    task automatic serve_ball();
        launch = 1'b1;
        tick_once(0);
        launch = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_pos(input string name, input int ex, input int ey);
        check({name, "_x"}, ball_x, ex);
        check({name, "_y"}, ball_y, ey);
    endtask

    int n, hit_base, miss_base;

    initial begin
        reset = 1'b1; tick75hz = 1'b0; launch = 1'b0; brick_bounce = 1'b0;
        bar_x_l = 12'd0; bar_x_r = 12'd119;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check_pos("reset", 316, 300);
        check("reset_lives", lives, 3);
        check("reset_game_over", game_over, 0);
        check("reset_paddle_hit", paddle_hit, 0);

        repeat (3) tick_once(0);
        check_pos("serve_hold", 316, 300);

        serve_ball();
        check_pos("launch_tick", 316, 300);
        tick_once(0);
        check_pos("first_move", 318, 298);
        repeat (148) tick_once(0);
        check_pos("tick149", 614, 2);

        // Brick hit on the same tick as the top-wall bounce: a single flip.
        tick_once(1);
        check_pos("top_brick", 616, 4);
        tick_once(0);
        check_pos("still_down", 618, 6);

        // Brick hit between ticks, consumed by the following tick.
        @(negedge clk); brick_bounce = 1'b1;
        @(negedge clk); brick_bounce = 1'b0;
        tick_once(0);
        check_pos("brick_flip", 620, 4);

        pulse_reset();
        check_pos("mid_play_reset", 316, 300);
        check("mid_play_reset_lives", lives, 3);
        serve_ball();
        tick_once(0);
        check_pos("reserve_dirs", 318, 298);

        // Full-width paddle: the ball must bounce and never be lost.
        pulse_reset();
        bar_x_r = 12'd639;
        hit_base = hit_seen;
        serve_ball();
        n = 0;
        do begin
            tick_once(0);
            n++;
        end while (!paddle_hit && n < 500);
        check("paddle_hit_seen", paddle_hit, 1);
        check("paddle_hit_tick", n, 360);
        check("paddle_hit_y", ball_y, 420);
        repeat (5) tick_once(0);
        check("paddle_hit_count", hit_seen - hit_base, 1);
        check("after_hit_y", ball_y, 410);
        miss_base = miss_seen;
        repeat (600) tick_once(0);
        check("full_paddle_no_miss", miss_seen - miss_base, 0);

        // Narrow paddle: three misses end the game.
        pulse_reset();
        bar_x_r = 12'd119;
        for (int life = 0; life < 3; life++) begin
            serve_ball();
            n = 0;
            do begin
                tick_once(0);
                n++;
            end while (!miss && n < 600);
            check("miss_seen", miss, 1);
            check("miss_tick", n, 385);
            check_pos("miss_freeze", 176, 472);
            check("lives_after_miss", lives, 2 - life);
            repeat (74) tick_once(0);
            check_pos("miss_hold", 176, 472);
            check("miss_hold_over", game_over, 0);
            tick_once(0);
            if (life < 2) begin
                check_pos("reserved", 316, 300);
                check("reserved_over", game_over, 0);
            end else begin
                check("game_over_set", game_over, 1);
                check("game_over_ball_on", ball_on, 0);
            end
        end

        launch = 1'b1;
        repeat (3) tick_once(0);
        launch = 1'b0;
        check("over_sticky", game_over, 1);
        check_pos("over_frozen", 176, 472);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
